fp_comp_arb: RTL

Round-robin arbiter and sequencer that shares one `fp_comp` comparator among N requesters. It accepts one compare request at a time and latches the operands. It drives the comparator, waits out the comparator's fixed pipeline latency, then returns the registered result tagged with the requester index. It sits between the FPU's issue ports and the single comparator instance.

---
 rtl/fp_comp_arb.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_comp_arb.sv
// Round-robin arbiter/sequencer sharing one fp_comp comparator among N requesters.
// Optional WAIT timeout enabled by defining FP_COMP_ARB_TIMEOUT_EN.
module fp_comp_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 32,
    parameter int unsigned LAT = 2,
    parameter int unsigned TO  = 15,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  req_a,
    input  logic [N*W-1:0]  req_b,
    output logic [N-1:0]    gnt,
    output logic            busy,
    output logic            rsp_valid,
    output logic [IW-1:0]   rsp_id,
    output logic            rsp_eq,
    output logic            rsp_great,
    output logic            rsp_less,
    output logic            rsp_inv,
    output logic            rsp_to,
    output logic [W-1:0]    cmp_in1,
    output logic [W-1:0]    cmp_in2,
    output logic            cmp_act,
    input  logic            cmp_eq,
    input  logic            cmp_great,
    input  logic            cmp_less,
    input  logic            cmp_done,
    input  logic            cmp_inv
);

    localparam int unsigned CMAX = (TO > LAT) ? TO : LAT;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [CW:0]     cnt_inc;
    logic            lat_hit, done_ok;

    logic            found;
    logic [IW-1:0]   sel;
    logic [W-1:0]    pick_a, pick_b;

    logic [N-1:0]    gnt_d;
    logic            busy_d, rsp_valid_d, cmp_act_d;
    logic [IW-1:0]   id_d;
    logic [W-1:0]    in1_d, in2_d;
    logic            eq_d, great_d, less_d, inv_d;

    // Counter value after this WAIT cycle; results count only once it reaches LAT
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign lat_hit = (cnt_inc >= (CW+1)'(LAT));
    assign done_ok = lat_hit && cmp_done;

`ifdef FP_COMP_ARB_TIMEOUT_EN
    logic to_hit, to_d, rsp_to_q;
    assign to_hit = (cnt_inc == (CW+1)'(TO));
    assign rsp_to = rsp_to_q;
`else
    assign rsp_to = 1'b0;
`endif

    // First requester at or after ptr, wrapping N-1 -> 0
    always_comb begin : arb_pick
        int unsigned pos;
        found  = 1'b0;
        sel    = '0;
        pick_a = '0;
        pick_b = '0;
        pos    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = (32'(ptr) + off) % N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i] && (pos == i)) begin
                    found  = 1'b1;
                    sel    = IW'(i);
                    pick_a = req_a[i*W +: W];
                    pick_b = req_b[i*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_ok) state_nxt = S_RESP;
`ifdef FP_COMP_ARB_TIMEOUT_EN
                else if (to_hit) state_nxt = S_RESP;
`endif
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of all registered outputs and datapath state
    always_comb begin
        gnt_d       = '0;
        cmp_act_d   = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = (state_nxt != S_IDLE);
        id_d        = rsp_id;
        in1_d       = cmp_in1;
        in2_d       = cmp_in2;
        ptr_d       = ptr;
        cnt_d       = cnt;
        eq_d        = rsp_eq;
        great_d     = rsp_great;
        less_d      = rsp_less;
        inv_d       = rsp_inv;
`ifdef FP_COMP_ARB_TIMEOUT_EN
        to_d        = rsp_to_q;
`endif
        case (state)
            S_IDLE: begin
                if (found) begin
                    gnt_d     = N'(1) << sel;
                    id_d      = sel;
                    in1_d     = pick_a;
                    in2_d     = pick_b;
                    cmp_act_d = 1'b1;
                end
            end
            S_ISSUE: cnt_d = '0;
            S_WAIT: begin
                if (cnt < CW'(CMAX)) cnt_d = cnt + 1'b1;
                if (done_ok) begin
                    eq_d        = cmp_eq;
                    great_d     = cmp_great;
                    less_d      = cmp_less;
                    inv_d       = cmp_inv;
                    rsp_valid_d = 1'b1;
`ifdef FP_COMP_ARB_TIMEOUT_EN
                    to_d        = 1'b0;
                end else if (to_hit) begin
                    eq_d        = 1'b0;
                    great_d     = 1'b0;
                    less_d      = 1'b0;
                    inv_d       = 1'b1;
                    to_d        = 1'b1;
                    rsp_valid_d = 1'b1;
`endif
                end
            end
            S_RESP: ptr_d = (rsp_id == IW'(N-1)) ? '0 : rsp_id + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_eq    <= 1'b0;
            rsp_great <= 1'b0;
            rsp_less  <= 1'b0;
            rsp_inv   <= 1'b0;
            cmp_in1   <= '0;
            cmp_in2   <= '0;
            cmp_act   <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
`ifdef FP_COMP_ARB_TIMEOUT_EN
            rsp_to_q  <= 1'b0;
`endif
        end else begin
            gnt       <= gnt_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= id_d;
            rsp_eq    <= eq_d;
            rsp_great <= great_d;
            rsp_less  <= less_d;
            rsp_inv   <= inv_d;
            cmp_in1   <= in1_d;
            cmp_in2   <= in2_d;
            cmp_act   <= cmp_act_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
`ifdef FP_COMP_ARB_TIMEOUT_EN
            rsp_to_q  <= to_d;
`endif
        end
    end

endmodule
